// File: rtl/dmrs_pkg.sv
// Shared constants, FSM encoding and Gold-sequence helpers for the PUSCH DMRS generator.
package dmrs_pkg;

  localparam int NC       = 1600;
  localparam int MAX_RE   = 600;
  localparam int AMP      = 91;
  localparam int WARM_CYC = NC / 2;
  localparam int CNT_W    = $clog2(((WARM_CYC > MAX_RE) ? WARM_CYC : MAX_RE) + 1);

  localparam logic [30:0] X1_INIT = 31'h0000_0001;
  // tap masks over x(n)..x(n+30): x1 uses n, n+3; x2 uses n..n+3
  localparam logic [30:0] X1_TAPS = 31'h0000_0009;
  localparam logic [30:0] X2_TAPS = 31'h0000_000F;

  typedef enum logic [1:0] {IDLE, WARMUP, GEN, DONE} state_t;

  // Two LFSR steps at once; bit i of the register holds x(n+i).
  function automatic logic [30:0] step2(input logic [30:0] x, input logic [30:0] taps);
    logic f0;
    logic f1;
    f0 = ^(x & taps);
    f1 = ^({1'b0, x[30:1]} & taps);
    return {f1, f0, x[30:2]};
  endfunction

endpackage

// File: rtl/dmrs_gen_if.sv
// Request/sample bus of the DMRS generator.
interface dmrs_gen_if #(parameter int WIDTH = 9);
  logic                    start;
  logic [30:0]             c_init;
  logic [9:0]              num_re;
  logic                    DMRS_valid;
  logic signed [WIDTH-1:0] DMRS_r;
  logic signed [WIDTH-1:0] DMRS_i;
  logic                    busy;
  logic                    done;

  modport master (output start, c_init, num_re,
                  input  DMRS_valid, DMRS_r, DMRS_i, busy, done);
  modport slave  (input  start, c_init, num_re,
                  output DMRS_valid, DMRS_r, DMRS_i, busy, done);
endinterface

// File: rtl/dmrs_gen_gold_seq2.sv
// x1/x2 Gold LFSR pair advancing two steps per cycle; c0/c1 = c(2m), c(2m+1).
module gold_seq2
  import dmrs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [30:0] c_init,
  input  logic        adv,
  output logic        c0,
  output logic        c1
);

  logic [30:0] r_x1;
  logic [30:0] r_x2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (load) begin
      r_x1 <= X1_INIT;
      r_x2 <= c_init;
    end else if (adv) begin
      r_x1 <= step2(r_x1, X1_TAPS);
      r_x2 <= step2(r_x2, X2_TAPS);
    end
  end

  assign c0 = r_x1[0] ^ r_x2[0];
  assign c1 = r_x1[1] ^ r_x2[1];

endmodule

// File: rtl/dmrs_gen.sv
// PUSCH DMRS generator: Gold sequence warm-up, then a gap-free QPSK sample burst.
module dmrs_gen
  import dmrs_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic       clk,
  input  logic       reset,
  dmrs_gen_if.slave  bus
);

  localparam logic signed [WIDTH-1:0] P_AMP = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] N_AMP = WIDTH'(-AMP);

  state_t             r_state;
  state_t             w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [9:0]         r_num;
  logic [9:0]         w_num_clamp;
  logic               w_load;
  logic               w_adv;
  logic               w_emit;
  logic               w_c0;
  logic               w_c1;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic signed [WIDTH-1:0] r_re;
  logic signed [WIDTH-1:0] r_im;

  assign w_num_clamp = (bus.num_re > 10'(MAX_RE)) ? 10'(MAX_RE) : bus.num_re;

  gold_seq2 u_gold (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .c_init (bus.c_init),
    .adv    (w_adv),
    .c0     (w_c0),
    .c1     (w_c1)
  );

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_emit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load    = 1'b1;
          w_cnt_nxt = '0;
          w_nxt     = (w_num_clamp == 10'd0) ? DONE : WARMUP;
        end
      end
      WARMUP: begin
        w_adv = 1'b1;
        if (r_cnt == CNT_W'(WARM_CYC - 1)) begin
          w_cnt_nxt = '0;
          w_nxt     = GEN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GEN: begin
        w_adv  = 1'b1;
        w_emit = 1'b1;
        if (r_cnt == CNT_W'(r_num - 10'd1)) begin
          w_cnt_nxt = '0;
          w_nxt     = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_num   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_num <= w_num_clamp;
    end
  end

  // busy covers the output-register lag so it drops together with the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= '0;
      r_im    <= '0;
    end else begin
      r_valid <= w_emit;
      r_busy  <= (w_nxt == WARMUP) || (w_nxt == GEN) || w_emit;
      r_done  <= (r_state == DONE);
      r_re    <= w_emit ? (w_c0 ? N_AMP : P_AMP) : '0;
      r_im    <= w_emit ? (w_c1 ? N_AMP : P_AMP) : '0;
    end
  end

  assign bus.DMRS_valid = r_valid;
  assign bus.DMRS_r     = r_re;
  assign bus.DMRS_i     = r_im;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_dmrs_gen.sv
// Directed bench for dmrs_gen: bit-serial Gold reference, timing/length table, reset and start-ignore corners.
module tb_dmrs_gen;

  localparam int WIDTH  = 9;
  localparam int NC     = 1600;
  localparam int MAX_RE = 600;
  localparam int AMP    = 91;
  localparam int LEN    = NC + 2 * MAX_RE;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dmrs_gen_if #(.WIDTH(WIDTH)) bus ();

  dmrs_gen #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit x1 [0:LEN+30];
  bit x2 [0:LEN+30];
  bit c_ref [0:2*MAX_RE-1];

  typedef struct {
    logic [30:0] ci;
    logic [9:0]  nre;
    int          n;
    int          first;
    int          dn;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one LFSR step at a time, straight from the recurrences
  task automatic build_ref(input logic [30:0] ci);
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = ci[n];
    end
    for (int n = 0; n < LEN; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int n = 0; n < 2 * MAX_RE; n++) c_ref[n] = x1[n+NC] ^ x2[n+NC];
  endtask

  task automatic run_tx(input logic [30:0] ci, input logic [9:0] nre, input int exp_n,
                        input int exp_first, input int exp_done, input bit inj, input int rst_at);
    int first, cnt, gap, dj, bsy, bad_s, nz, last_v, busy0, er, ei, bidx, bgot, bexp, post;
    build_ref(ci);
    @(negedge clk);
    bus.start = 1'b1; bus.c_init = ci; bus.num_re = nre;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    first = -1; cnt = 0; gap = 0; dj = -1; bsy = 0; bad_s = 0; nz = 0; last_v = -1;
    bidx = -1; bgot = 0; bexp = 0;
    busy0 = int'(bus.busy);
    for (int j = 0; j < 1600 && dj < 0; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.DMRS_valid) begin
        if (first < 0) first = j;
        else if (last_v != j - 1) gap++;
        last_v = j;
        er = c_ref[2*cnt]   ? -AMP : AMP;
        ei = c_ref[2*cnt+1] ? -AMP : AMP;
        if (cnt < MAX_RE && (int'(bus.DMRS_r) != er || int'(bus.DMRS_i) != ei)) begin
          if (bad_s == 0) begin
            bidx = cnt; bgot = int'(bus.DMRS_r) * 1000 + int'(bus.DMRS_i); bexp = er * 1000 + ei;
          end
          bad_s++;
        end
        cnt++;
      end else if (bus.DMRS_r != 0 || bus.DMRS_i != 0) begin
        nz++;
      end
      if (bus.busy) bsy++;
      if (bus.done) dj = j;
      if (rst_at >= 0 && j == rst_at) begin
        chk("samples_before_reset", bad_s, 0);
        reset = 1'b1;
        #1;
        chk("outputs_at_reset", int'({bus.DMRS_valid, bus.busy, bus.done,
            bus.DMRS_r != 0, bus.DMRS_i != 0}), 0);
        post = 0;
        repeat (3) begin
          @(negedge clk);
          post += int'(bus.done) + int'(bus.busy) + int'(bus.DMRS_valid);
        end
        chk("quiet_during_reset", post, 0);
        reset = 1'b0;
        return;
      end
      bus.start = inj && (j == 400 || j == 810);
      if (bus.start) begin bus.c_init = ~ci; bus.num_re = 10'd5; end
    end
    bus.start = 1'b0;
    chk("first_valid", first, exp_first);
    chk("sample_count", cnt, exp_n);
    chk("valid_gaps", gap, 0);
    chk("done_cycle", dj, exp_done);
    chk("busy_cycles", bsy, (exp_n == 0) ? 0 : 801 + exp_n);
    chk("busy_after_start", busy0, (exp_n != 0) ? 1 : 0);
    chk("iq_zero_when_idle", nz, 0);
    if (bad_s != 0) $display("FAIL iq_first_bad: sample %0d got %0d expected %0d (re*1000+im)", bidx, bgot, bexp);
    chk("iq_mismatches", bad_s, 0);
    post = 0;
    repeat (3) begin
      @(negedge clk);
      post += int'(bus.busy) + int'(bus.DMRS_valid) + int'(bus.done);
    end
    chk("idle_after_done", post, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.c_init = '0; bus.num_re = '0;
    tbl[0] = '{31'h0000000,  10'd12,  12,  801,  813};
    tbl[1] = '{31'h1234567,  10'd600, 600, 801, 1401};
    tbl[2] = '{31'h2AAAAAA,  10'd700, 600, 801, 1401};
    tbl[3] = '{31'h7FFFFFFF, 10'd0,   0,   -1,  1};
    tbl[4] = '{31'h0000001,  10'd1,   1,   801, 802};
    tbl[5] = '{31'h5A5A5A5,  10'd601, 600, 801, 1401};

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'({bus.DMRS_valid, bus.busy, bus.done,
        bus.DMRS_r != 0, bus.DMRS_i != 0}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_tx(tbl[v].ci, tbl[v].nre, tbl[v].n, tbl[v].first, tbl[v].dn, 1'b0, -1);

    // start pulses in WARMUP and GEN must not disturb the running request
    run_tx(31'h0ABCDEF, 10'd100, 100, 801, 901, 1'b1, -1);

    // reset in sample 50, then a clean rerun of the same sequence
    run_tx(31'h1234567, 10'd600, 600, 801, 1401, 1'b0, 851);
    @(negedge clk);
    run_tx(31'h1234567, 10'd600, 600, 801, 1401, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
